// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, opcodes and FSM encodings for alu_stage
//
// Purpose: single place for the datapath width, opcode values and the
// alu_stage state encoding so the top and the multiplier agree.
// Ports: none (package).
// Optional feature macro: ALU_STAGE_MUL_EN (ST_MUL is only reachable when set).

package alu_pkg;

  localparam int WIDTH      = 8;
  localparam int MUL_CYCLES = 8;   // one shift-add step per multiplier bit
  localparam int MUL_CNT_W  = 3;   // enough to count MUL_CYCLES iterations

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_multiplier_8x8.sv
// rtl/seq_multiplier_8x8.sv - iterative shift-add 8x8 unsigned multiplier
//
// Purpose: one shift-add step per clock after load; after MUL_CYCLES steps
// the full 16-bit product is presented on product_o together with last_iter_o.
// Ports:
//   clk_i        rising-edge clock
//   load_i       captures a_i/b_i and restarts the iteration count
//   a_i, b_i     unsigned operands
//   product_o    running product including the step taken at the next edge
//   last_iter_o  high in the cycle whose closing edge is the final iteration
// Optional feature macro: ALU_STAGE_MUL_EN (module only exists when set).

`ifdef ALU_STAGE_MUL_EN
module seq_multiplier_8x8
  import alu_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 load_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 last_iter_o
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [MUL_CNT_W-1:0] cnt_q;

  // The partial product of the current step is folded in combinationally so
  // the owner can capture the complete product on the final iteration edge
  // instead of one cycle later.
  assign product_o   = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign last_iter_o = (cnt_q == MUL_CNT_W'(MUL_CYCLES - 1));

  // No reset: every multiply starts with load_i, and the owner ignores the
  // outputs outside of an active multiply.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      mcand_q <= {{WIDTH{1'b0}}, a_i};
      mplr_q  <= b_i;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= product_o;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + MUL_CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - execution stage: single-cycle ALU plus optional multiply
//
// Purpose: consumes the R1/R2 operand bytes and an opcode on start, and
// produces a registered result with carry and zero flags. The result feeds
// back into the R2 input mux, so results and flags hold until the next
// completion or CLR.
// Ports:
//   clock   rising-edge clock
//   CLR     synchronous active-high reset, priority over start, aborts MUL
//   start   request, sampled while idle (ignored while busy)
//   op      opcode, sampled with start
//   a, b    unsigned operands
//   result  registered result
//   carry   registered carry / borrow / overflow flag
//   zero    registered, high when result == 0
//   busy    high while a multiply is in progress
//   done    one-cycle pulse in the cycle after result/flags update
// Optional feature macro: ALU_STAGE_MUL_EN
//   defined   - 8-cycle shift-add multiply for op 111, busy/MUL state present
//   undefined - op 111 completes in one cycle with result 0, carry 0; busy = 0

module alu_stage
  import alu_pkg::*;
(
  input  logic             clock,
  input  logic             CLR,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  // Single-cycle datapath
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  // Bit WIDTH of the widened difference is set exactly when a < b.
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res   = {a[WIDTH-2:0], 1'b0};
        alu_carry = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, a[WIDTH-1:1]};
        alu_carry = a[0];
      end
      // Handled by the multiplier when present; otherwise a one-cycle zero.
      OP_MUL: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Completion write port shared by the single-cycle and multiply paths
  logic             wr_en;
  logic [WIDTH-1:0] wr_res;
  logic             wr_carry;

`ifdef ALU_STAGE_MUL_EN
  state_e             state_q, state_d;
  logic               mul_load;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_last;

  assign mul_load = (state_q == ST_IDLE) && start && (op == OP_MUL);

  seq_multiplier_8x8 u_mul (
    .clk_i       (clock),
    .load_i      (mul_load),
    .a_i         (a),
    .b_i         (b),
    .product_o   (mul_product),
    .last_iter_o (mul_last)
  );

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    wr_res   = alu_res;
    wr_carry = alu_carry;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      // start is deliberately not looked at here: requests during a
      // multiply are dropped.
      ST_MUL: begin
        if (mul_last) begin
          wr_en    = 1'b1;
          wr_res   = mul_product[WIDTH-1:0];
          wr_carry = |mul_product[2*WIDTH-1:WIDTH];
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (CLR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q == ST_MUL);
`else
  always_comb begin
    wr_en    = start;
    wr_res   = alu_res;
    wr_carry = alu_carry;
  end

  assign busy = 1'b0;
`endif

  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = wr_en;
    if (wr_en) begin
      result_d = wr_res;
      carry_d  = wr_carry;
      zero_d   = (wr_res == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (CLR) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign done   = done_q;

endmodule
